// File: rtl/he_video_in.sv
// he_video_in: front end of the histogram-equalisation core.
// Converts a DE-framed RGB888 stream to 8-bit luma and frames it as a
// pixel stream. src_last is issued only after exactly WIDTH*HEIGHT pixels
// have been accepted. Short frames, short lines and overruns pulse frame_err.
module he_video_in #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [23:0] rgb_in,
  output logic        src_valid,
  output logic [7:0]  src_data,
  output logic        src_last,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int STAGES = 2;
  localparam int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Weighted colour products held in the first pipeline stage.
  typedef struct packed {
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
  } prod_t;

  state_t          state, state_nxt;
  logic            vs_d, de_d;
  logic [CW-1:0]   col, col_nxt, col_eff;
  logic [RW-1:0]   row, row_nxt, row_eff;
  logic            vs_rise, accept, at_eol, at_eof, pix_last;
  logic            short_line, err_nxt;
  logic [STAGES-1:0] vld_pipe, last_pipe;
  prod_t           s1;

  // Frame control: edge detect, pixel acceptance, position tracking, errors.
  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    vs_rise    = vs_in & ~vs_d;
    // A sync edge restarts the frame, so a coincident pixel is col0/row0.
    col_eff    = vs_rise ? '0 : col;
    row_eff    = vs_rise ? '0 : row;
    accept     = de_in & (vs_rise | (state == ACTIVE));
    at_eol     = (col_eff == CW'(WIDTH - 1));
    at_eof     = (row_eff == RW'(HEIGHT - 1));
    pix_last   = accept & at_eol & at_eof;
    // DE dropping mid-line means the line came up short.
    short_line = (state == ACTIVE) & de_d & ~de_in & (col != '0);
    // Several simultaneous causes fold into one pulse.
    err_nxt    = (vs_rise & (state == ACTIVE)) | short_line |
                 ((state == DONE) & de_in & ~vs_rise);

    if (vs_rise) begin
      state_nxt = ACTIVE;
      col_nxt   = '0;
      row_nxt   = '0;
    end else if (short_line) begin
      state_nxt = IDLE;
    end

    if (accept) begin
      if (pix_last) begin
        state_nxt = DONE;
        col_nxt   = '0;
        row_nxt   = '0;
      end else if (at_eol) begin
        col_nxt   = '0;
        row_nxt   = row_eff + 1'b1;
      end else begin
        col_nxt   = col_eff + 1'b1;
        row_nxt   = row_eff;
      end
    end
  end

  // Control state registers; reset discards any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
      col       <= '0;
      row       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      vs_d      <= vs_in;
      de_d      <= de_in;
      col       <= col_nxt;
      row       <= row_nxt;
      frame_err <= err_nxt;
    end
  end

  // Valid/last tags travel alongside the data as shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0], accept};
      last_pipe <= {vld_pipe[0] & last_pipe[0], pix_last};
    end
  end

  // S1: luma products of accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (accept) begin
      s1.pr <= 16'(rgb_in[23:16]) * 16'd77;
      s1.pg <= 16'(rgb_in[15:8])  * 16'd150;
      s1.pb <= 16'(rgb_in[7:0])   * 16'd29;
    end
  end

  // S2: sum and scale; weights total 256 so the sum never exceeds 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_data  <= '0;
      frame_cnt <= '0;
    end else begin
      if (vld_pipe[0])
        src_data <= 8'((s1.pr + s1.pg + s1.pb) >> 8);
      if (vld_pipe[0] & last_pipe[0])
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign src_valid = vld_pipe[1];
  assign src_last  = last_pipe[1];
  assign busy      = (state == ACTIVE);

endmodule

// File: tb/tb_he_video_in.sv
// Directed bench for he_video_in with a 4x2 frame.
// Each table record holds the inputs for one cycle and the outputs
// expected during that same cycle (sampled on the falling edge).
module tb_he_video_in;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs_in, de_in;
  logic [23:0] rgb_in;
  logic        src_valid, src_last, frame_err, busy;
  logic [7:0]  src_data;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int idx    = 0;

  he_video_in #(.WIDTH(4), .HEIGHT(2)) dut (
    .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .de_in(de_in), .rgb_in(rgb_in),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        e;
    logic        b;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic push(input logic vs, input logic de, input logic [23:0] rgb,
                      input logic v, input logic [7:0] d, input logic l,
                      input logic e, input logic b, input int cnt);
    vec_t r;
    r.vs = vs; r.de = de; r.rgb = rgb;
    r.v = v; r.d = d; r.l = l; r.e = e; r.b = b; r.cnt = 16'(cnt);
    tbl.push_back(r);
  endtask

  // Nominal 8-pixel frame: vs cycle, 8 DE cycles, outputs 2 cycles behind.
  task automatic frame8(input logic [7:0][23:0] px, input logic [7:0][7:0] y, input int c0);
    push(1, 0, 24'h0, 0, 8'h00, 0, 0, 0, c0);
    for (int k = 0; k < 8; k++)
      push(0, 1, px[k], (k >= 2), y[(k + 6) % 8], 0, 0, 1, c0);
    push(0, 0, 24'h0, 1, y[6], 0, 0, 0, c0);
    push(0, 0, 24'h0, 1, y[7], 1, 0, 0, c0 + 1);
    push(0, 0, 24'h0, 0, 8'h00, 0, 0, 0, c0 + 1);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      @(negedge clk);
      chk("src_valid", idx, 16'(src_valid), 16'(tbl[i].v));
      chk("src_last",  idx, 16'(src_last),  16'(tbl[i].l));
      chk("frame_err", idx, 16'(frame_err), 16'(tbl[i].e));
      chk("busy",      idx, 16'(busy),      16'(tbl[i].b));
      chk("frame_cnt", idx, frame_cnt,      tbl[i].cnt);
      if (tbl[i].v)
        chk("src_data", idx, 16'(src_data), 16'(tbl[i].d));
      vs_in  = tbl[i].vs;
      de_in  = tbl[i].de;
      rgb_in = tbl[i].rgb;
      idx++;
    end
    tbl.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, idx, 16'(src_valid), 16'h0);
    chk({tag, "_data"},  idx, 16'(src_data),  16'h0);
    chk({tag, "_last"},  idx, 16'(src_last),  16'h0);
    chk({tag, "_err"},   idx, 16'(frame_err), 16'h0);
    chk({tag, "_cnt"},   idx, frame_cnt,      16'h0);
    chk({tag, "_busy"},  idx, 16'(busy),      16'h0);
    idx++;
  endtask

  initial begin
    rst_n = 1'b0; vs_in = 1'b0; de_in = 1'b0; rgb_in = 24'h0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;

    // 1. nominal white frame
    frame8({8{24'hFFFFFF}}, {8{8'hFF}}, 0);

    // 2. colour math, frame padded with black to complete it
    frame8({24'h0, 24'h0, 24'h0, 24'h0, 24'h808080, 24'h0000FF, 24'h00FF00, 24'hFF0000},
           {8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h1C, 8'h95, 8'h4C}, 1);

    // 3. short frame: 5 pixels, then vs rises on the 6th with DE held high
    push(1, 0, 24'h0, 0, 8'h00, 0, 0, 0, 2);
    for (int k = 1; k <= 13; k++)
      push((k == 6), 1, 24'h808080, (k >= 3), 8'h80, 0, (k == 7), 1, 2);
    push(0, 0, 24'h0, 1, 8'h80, 0, 0, 0, 2);
    push(0, 0, 24'h0, 1, 8'h80, 1, 0, 0, 3);
    push(0, 0, 24'h0, 0, 8'h00, 0, 0, 0, 3);

    // 4. short line: 2 pixels then DE drops; later pixels ignored
    push(1, 0, 24'h0,      0, 8'h00, 0, 0, 0, 3);
    push(0, 1, 24'h808080, 0, 8'h00, 0, 0, 1, 3);
    push(0, 1, 24'h808080, 0, 8'h00, 0, 0, 1, 3);
    push(0, 0, 24'h0,      1, 8'h80, 0, 0, 1, 3);
    push(0, 0, 24'h0,      1, 8'h80, 0, 1, 0, 3);
    push(0, 1, 24'h808080, 0, 8'h00, 0, 0, 0, 3);
    push(0, 1, 24'h808080, 0, 8'h00, 0, 0, 0, 3);
    push(0, 1, 24'h808080, 0, 8'h00, 0, 0, 0, 3);
    push(0, 0, 24'h0,      0, 8'h00, 0, 0, 0, 3);
    push(0, 0, 24'h0,      0, 8'h00, 0, 0, 0, 3);

    // 5. overrun: 9 pixels, the 9th is dropped and flagged
    push(1, 0, 24'h0, 0, 8'h00, 0, 0, 0, 3);
    for (int k = 1; k <= 9; k++)
      push(0, 1, 24'h0000FF, (k >= 3), 8'h1C, 0, 0, (k <= 8), 3);
    push(0, 0, 24'h0, 1, 8'h1C, 1, 1, 0, 4);
    push(0, 0, 24'h0, 0, 8'h00, 0, 0, 0, 4);
    push(0, 0, 24'h0, 0, 8'h00, 0, 0, 0, 4);

    run_tbl();

    // 6. async reset mid-frame after 3 pixels
    @(negedge clk); vs_in = 1'b1; de_in = 1'b0;
    @(negedge clk); vs_in = 1'b0; de_in = 1'b1; rgb_in = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", idx, 16'(src_valid), 16'h1);
    chk("pre_rst_busy",  idx, 16'(busy),      16'h1);
    chk("pre_rst_cnt",   idx, frame_cnt,      16'h4);
    idx++;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // DE keeps running with no vs: nothing may come out
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("novs_valid", idx, 16'(src_valid), 16'h0);
      chk("novs_busy",  idx, 16'(busy),      16'h0);
      idx++;
    end
    de_in = 1'b0;
    frame8({8{24'hFFFFFF}}, {8{8'hFF}}, 0);
    run_tbl();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
